// File: rtl/uart_frame_parser.sv
// uart_frame_parser: decodes SYNC/CMD/LEN/payload/CHK command frames from a
// UART receiver byte stream and reports payload bytes, frame completion and errors.
//
// Ports:
//   clk      in   reference clock
//   rst      in   synchronous reset, active-low
//   I_DATA   in   received byte, valid when NrD=1
//   NrD      in   new-byte strobe, one cycle per byte
//   O_CMD    out  command byte of the current/last frame
//   O_LEN    out  length byte of the current/last frame
//   O_PDATA  out  payload byte, valid with PV
//   O_PIDX   out  0-based payload index of O_PDATA
//   PV       out  payload-valid pulse
//   FrD      out  frame-done pulse (checksum matched)
//   FrE      out  frame-error pulse
//   O_ERR    out  error code with FrE: 01 length, 10 checksum, 11 timeout
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 4160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] I_DATA,
  input  logic       NrD,
  output logic [7:0] O_CMD,
  output logic [7:0] O_LEN,
  output logic [7:0] O_PDATA,
  output logic [7:0] O_PIDX,
  output logic       PV,
  output logic       FrD,
  output logic       FrE,
  output logic [1:0] O_ERR
);

  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t        state_q;
  logic [7:0]    cmd_q, len_q, pdata_q, pidx_q;
  logic [7:0]    chk_q;
  logic [7:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic          pv_q, frd_q, fre_q;
  logic [1:0]    err_q;

  // Frame FSM; every output is a register, pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      pdata_q <= '0;
      pidx_q  <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pv_q    <= 1'b0;
      frd_q   <= 1'b0;
      fre_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      pv_q  <= 1'b0;
      frd_q <= 1'b0;
      fre_q <= 1'b0;
      if (NrD) begin
        // A byte always beats a timeout landing in the same cycle.
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (I_DATA == SYNC_BYTE) state_q <= S_CMD;
          end
          S_CMD: begin
            cmd_q   <= I_DATA;
            chk_q   <= I_DATA;
            state_q <= S_LEN;
          end
          S_LEN: begin
            len_q <= I_DATA;
            chk_q <= chk_q ^ I_DATA;
            cnt_q <= '0;
            if (I_DATA > MAX_LEN_B) begin
              fre_q   <= 1'b1;
              err_q   <= ERR_LEN;
              state_q <= S_IDLE;
            end else if (I_DATA == 8'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            pdata_q <= I_DATA;
            pidx_q  <= cnt_q;
            pv_q    <= 1'b1;
            chk_q   <= chk_q ^ I_DATA;
            // Counter wraps to 0 on the last byte so it never passes MAX_LEN-1.
            if (cnt_q == len_q - 8'd1) begin
              cnt_q   <= '0;
              state_q <= S_CHK;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          S_CHK: begin
            if (I_DATA == chk_q) begin
              frd_q <= 1'b1;
            end else begin
              fre_q <= 1'b1;
              err_q <= ERR_CHK;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        // Inter-byte watchdog; fires on the TIMEOUT-th idle cycle after a byte.
        if (tmo_q == TMO_LAST) begin
          tmo_q   <= '0;
          fre_q   <= 1'b1;
          err_q   <= ERR_TMO;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

  assign O_CMD   = cmd_q;
  assign O_LEN   = len_q;
  assign O_PDATA = pdata_q;
  assign O_PIDX  = pidx_q;
  assign PV      = pv_q;
  assign FrD     = frd_q;
  assign FrE     = fre_q;
  assign O_ERR   = err_q;

endmodule
